// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  // Result encoding as {greater, equal, less}
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  function automatic int cnt_width(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned compare; exactly one of gt/eq/lt is high.
module cmp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle unsigned comparator: scans MSB-first one 2-bit digit per cycle,
// exiting on the first unequal digit.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int DIGITS = WIDTH / 2,
  localparam int CNT_W  = cnt_width(WIDTH / 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             equal,
  output logic             less,
  output logic [CNT_W-1:0] digits_used
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_chk
    $error("serial_magnitude_comparator: WIDTH must be even and >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             greater_q, greater_d, equal_q, equal_d, less_q, less_d;
  logic [CNT_W-1:0] digits_used_q, digits_used_d;

  logic s_gt, s_eq, s_lt;

  cmp2_slice u_slice (
    .x  (op_a_q[2*idx_q +: 2]),
    .y  (op_b_q[2*idx_q +: 2]),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    idx_d         = idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    greater_d     = greater_q;
    equal_d       = equal_q;
    less_d        = less_q;
    digits_used_d = digits_used_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d    = a;
          op_b_d    = b;
          idx_d     = IDX_LAST;
          greater_d = 1'b0;
          equal_d   = 1'b0;
          less_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!s_eq) begin
          greater_d     = s_gt;
          less_d        = s_lt;
          equal_d       = 1'b0;
          digits_used_d = CNT_W'(DIGITS) - CNT_W'(idx_q);
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else if (idx_q == '0) begin
          equal_d       = 1'b1;
          digits_used_d = CNT_W'(DIGITS);
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      greater_q     <= 1'b0;
      equal_q       <= 1'b0;
      less_q        <= 1'b0;
      digits_used_q <= '0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      greater_q     <= greater_d;
      equal_q       <= equal_d;
      less_q        <= less_d;
      digits_used_q <= digits_used_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign greater     = greater_q;
  assign equal       = equal_q;
  assign less        = less_q;
  assign digits_used = digits_used_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator (WIDTH = 8).
module tb_serial_magnitude_comparator;
  import cmp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, greater, equal, less;
  logic [2:0] digits_used;

  int checks = 0;
  int errors = 0;

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .greater(greater), .equal(equal),
    .less(less), .digits_used(digits_used)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns in the cycle after the accepting edge.
  task automatic do_start(input logic [7:0] ta, input logic [7:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done is seen; k = -1 if the budget expires.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin k = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, greater, equal, less, digits_used} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {busy, done, greater, equal, less, digits_used});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_release_idle: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_equal();
    int k, busy_cnt;
    do_start(8'hA5, 8'hA5);
    a = 8'h00; b = 8'hFF;  // operand changes while busy must not matter
    busy_cnt = 0;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      if (done) begin k = i; break; end
    end
    checks++;
    if (k !== 4) begin errors++; $display("FAIL eq_latency: got %0d expected 4", k); end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL eq_busy_cycles: got %0d expected 4", busy_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL eq_busy_in_done: got %b expected 0", busy); end
    checks++;
    if ({greater, equal, less} !== RES_EQ) begin
      errors++; $display("FAIL eq_result: got %b expected %b", {greater, equal, less}, RES_EQ);
    end
    checks++;
    if (digits_used !== 3'd4) begin errors++; $display("FAIL eq_digits: got %0d expected 4", digits_used); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL eq_done_pulse: got %b expected 0", done); end
    checks++;
    if ({greater, equal, less, digits_used} !== {RES_EQ, 3'd4}) begin
      errors++; $display("FAIL eq_hold: got %b expected %b", {greater, equal, less, digits_used}, {RES_EQ, 3'd4});
    end
  endtask

  task automatic test_cases();
    logic [7:0] va [4] = '{8'hC0, 8'h34, 8'h12, 8'h01};
    logic [7:0] vb [4] = '{8'h40, 8'h24, 8'h13, 8'h00};
    int         ek [4] = '{1, 2, 4, 4};
    logic [2:0] er [4] = '{RES_GT, RES_GT, RES_LT, RES_GT};
    int k;
    for (int t = 0; t < 4; t++) begin
      do_start(va[t], vb[t]);
      checks++;
      if ({busy, greater, equal, less} !== 4'b1000) begin
        errors++; $display("FAIL case%0d_run_flags: got %b expected 1000", t, {busy, greater, equal, less});
      end
      wait_done(k);
      checks++;
      if (k !== ek[t]) begin errors++; $display("FAIL case%0d_latency: got %0d expected %0d", t, k, ek[t]); end
      checks++;
      if ({greater, equal, less} !== er[t]) begin
        errors++; $display("FAIL case%0d_result: got %b expected %b", t, {greater, equal, less}, er[t]);
      end
      checks++;
      if (digits_used !== 3'(ek[t])) begin
        errors++; $display("FAIL case%0d_digits: got %0d expected %0d", t, digits_used, ek[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_start(8'h00, 8'hFF);
    // Start pulse while busy: must be ignored
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, greater, equal, less, digits_used} !== {1'b1, RES_LT, 3'd1}) begin
      errors++; $display("FAIL b2b_first: got %b expected %b",
                         {done, greater, equal, less, digits_used}, {1'b1, RES_LT, 3'd1});
    end
    // Third start raised in the done cycle
    a = 8'h80; b = 8'h7F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, greater, equal, less} !== 5'b10000) begin
      errors++; $display("FAIL b2b_accept: got %b expected 10000", {busy, done, greater, equal, less});
    end
    @(negedge clk);
    checks++;
    if ({done, greater, equal, less, digits_used} !== {1'b1, RES_GT, 3'd1}) begin
      errors++; $display("FAIL b2b_third: got %b expected %b",
                         {done, greater, equal, less, digits_used}, {1'b1, RES_GT, 3'd1});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL b2b_no_extra: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen_done;
    do_start(8'h55, 8'h55);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, greater, equal, less, digits_used} !== 8'h00) begin
      errors++; $display("FAIL midrun_async_reset: got %b expected 00000000",
                         {busy, done, greater, equal, less, digits_used});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL midrun_no_done: got %b expected 0", seen_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrun_idle: got %b expected 0", busy); end
  endtask

  task automatic test_after_reset();
    int k;
    do_start(8'h01, 8'h00);
    wait_done(k);
    checks++;
    if (k !== 4) begin errors++; $display("FAIL post_reset_latency: got %0d expected 4", k); end
    checks++;
    if ({greater, equal, less, digits_used} !== {RES_GT, 3'd4}) begin
      errors++; $display("FAIL post_reset_result: got %b expected %b",
                         {greater, equal, less, digits_used}, {RES_GT, 3'd4});
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_cases();
    test_back_to_back();
    test_reset_mid_run();
    test_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Multi-cycle unsigned magnitude comparator for WIDTH-bit operands.
- Reuses one 2-bit compare slice, scanning MSB-first one 2-bit digit per cycle, with early exit on the first unequal digit.
- Provides a start/busy/done handshake so datapath sequencers can share a single small comparator instead of a wide combinational one.

Parameters:
- WIDTH, default 8: operand width in bits. Must be even and ≥ 2; elaboration error otherwise.
- DIGITS, default WIDTH/2 (derived, not overridable): number of 2-bit digits.
- CNT_W, default $clog2(DIGITS+1) (derived): width of the digit counter output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a comparison; sampled only in IDLE.
- a  in  WIDTH  operand A (unsigned); captured on the accepted start.
- b  in  WIDTH  operand B (unsigned); captured on the accepted start.
- busy  out  1  high while a comparison is in progress (state RUN).
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- greater  out  1  A > B.
- equal  out  1  A == B.
- less  out  1  A < B.
- digits_used  out  CNT_W  number of digits examined for the last result (1..DIGITS).

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; busy, done, greater, equal, less = 0; digits_used = 0; operand registers and index = 0.
- States:
  - IDLE: busy = 0.
    - start = 1 at an edge: latch a and b into op_a and op_b, set idx = DIGITS-1, clear greater/equal/less, go to RUN.
    - start = 0: stay in IDLE.
  - RUN: busy = 1. Each cycle the slice compares op_a[2*idx+1:2*idx] against op_b[2*idx+1:2*idx].
    - Slice gt or lt: at the edge, register greater/less accordingly, equal = 0, digits_used = DIGITS-idx, pulse done, go to IDLE.
    - Slice eq and idx == 0: register equal = 1, digits_used = DIGITS, pulse done, go to IDLE.
    - Slice eq and idx > 0: decrement idx, stay in RUN.
- Latency: with start accepted at edge E0, done is high during the cycle following edge Ek, where k = digits examined (1..DIGITS). For WIDTH = 8, worst case is 4 edges.
- done: registered and high exactly one cycle; busy is 0 in that cycle.
- Result hold: greater, equal, less and digits_used hold their values until the next accepted start, which clears the three flags.
- One-hot result: greater/equal/less are one-hot after any done and all zero during RUN and after reset.
- start while busy: ignored; no queueing, no effect on the comparison in progress.
- start during the done cycle: accepted, since the state is IDLE. Enables back-to-back operations.
- Operand changes on a or b while busy: no effect; only the latched copies are used.
- Reset mid-RUN: immediate return to IDLE with all outputs 0; no done pulse.
- WIDTH = 2: DIGITS = 1; every comparison takes exactly 1 cycle.

Decomposition:
- Shared package cmp_pkg:
  - state typedef (IDLE, RUN), two-bit encoding.
  - result constants RES_GT, RES_EQ, RES_LT for bench scoreboards.
  - function cnt_width(digits).
- Sub-module cmp2_slice: purely combinational 2-bit compare.
  - Inputs x[1:0], y[1:0]; outputs gt, eq, lt, exactly one high.
  - Instantiated once in the controller; the controller owns all state, indexing and registering.

Test Plan (WIDTH = 8):
- Reset, then a = 8'hA5, b = 8'hA5, start for 1 cycle → busy high for 4 cycles; done on the 4th edge; equal = 1, greater = less = 0, digits_used = 4.
- a = 8'hC0, b = 8'h40 → done after 1 edge; greater = 1, digits_used = 1.
- a = 8'h34, b = 8'h24 → done after 2 edges; greater = 1, digits_used = 2.
- a = 8'h12, b = 8'h13 → done after 4 edges; less = 1, digits_used = 4.
- Start a = 8'h00, b = 8'hFF; on the following cycle pulse start with a = 8'hFF, b = 8'h00 while busy → second request ignored; less = 1 after 1 edge.
- Third start asserted in the done cycle → accepted immediately.
- Start a = 8'h55, b = 8'h55; drop rst_n after 2 edges → all outputs 0 asynchronously; no done pulse.
- After reset release, start a = 8'h01, b = 8'h00 → greater = 1, digits_used = 4.
